// File: rtl/kl8e_console.sv
// kl8e_console -- KL8E-style console teletype controller.
//
// Holds the keyboard buffer/flag, printer buffer/flag and interrupt enable.
// It decodes the group-603x (keyboard) and 604x (printer) IOT strobes from
// the IOT decoder and drives skip / AC-clear / AC-input back into the CPU
// datapath. Byte-wide valid/ready streams connect to the UART.
//
// Ports:
//   clk, reset         system clock; synchronous active-high reset
//   IR[2:0]            low octal digit of the IOT instruction
//   IOT603x, IOT604x   keyboard / printer device selects
//   DONE               one-cycle commit strobe at the end of the IOT
//   AC[7:0]            accumulator (printer data, KIE source in AC[0])
//   acClear, acIn      combinational AC clear / OR-in terms
//   skip               combinational skip request
//   irq                interrupt request
//   rxData/rxValid/rxReady   keyboard byte stream from the UART receiver
//   txData/txValid/txReady   printer byte stream to the UART transmitter
//   kbdFlag, ttyFlag   flag state for front panel / debug

module kl8e_console (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] IR,
  input  logic       IOT603x,
  input  logic       IOT604x,
  input  logic       DONE,
  input  logic [7:0] AC,
  output logic       acClear,
  output logic [7:0] acIn,
  output logic       skip,
  output logic       irq,
  input  logic [7:0] rxData,
  input  logic       rxValid,
  output logic       rxReady,
  output logic [7:0] txData,
  output logic       txValid,
  input  logic       txReady,
  output logic       kbdFlag,
  output logic       ttyFlag
);

  localparam logic IDLE = 1'b0;
  localparam logic SEND = 1'b1;

  logic [7:0] kbd_buf;
  logic       kbd_flag;
  logic [7:0] tty_buf;
  logic       tty_flag;
  logic       ie;
  logic       state;

  // Commit-cycle strobes for each device.
  logic k_commit;
  logic t_commit;
  logic rx_fire;
  logic tx_fire;
  logic kbd_clear;
  logic tty_clear;
  logic tty_set;
  logic tx_start;

  assign k_commit  = IOT603x & DONE;
  assign t_commit  = IOT604x & DONE;
  assign rx_fire   = rxValid & ~kbd_flag;
  assign tx_fire   = (state == SEND) & txReady;

  // KCF, KCC, KRB clear the keyboard flag.
  assign kbd_clear = k_commit & ((IR == 3'd0) | (IR == 3'd2) | (IR == 3'd6));
  // TCF, TLS clear the printer flag; TFL sets it.
  assign tty_clear = t_commit & ((IR == 3'd2) | (IR == 3'd6));
  assign tty_set   = t_commit & (IR == 3'd0);
  // TPC/TLS only start a transfer when the transmitter is idle; a request
  // arriving mid-send is dropped rather than corrupting the held byte.
  assign tx_start  = t_commit & ((IR == 3'd4) | (IR == 3'd6)) & (state == IDLE);

  // CPU-facing decode follows the selects for the whole IOT, not just DONE.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    acClear = 1'b0;
    acIn    = 8'h00;
    skip    = 1'b0;
    if (IOT603x) begin
      case (IR)
        3'd1:    skip    = kbd_flag;
        3'd2:    acClear = 1'b1;
        3'd4:    acIn    = kbd_buf;
        3'd6: begin
          acClear = 1'b1;
          acIn    = kbd_buf;
        end
        default: ;
      endcase
    end else if (IOT604x) begin
      case (IR)
        3'd1:    skip = tty_flag;
        3'd5:    skip = kbd_flag | tty_flag;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every update in
    // this block sees the pre-edge values of the others.
    if (reset) begin
      kbd_buf  <= 8'h00;
      kbd_flag <= 1'b0;
      tty_buf  <= 8'h00;
      tty_flag <= 1'b0;
      ie       <= 1'b1;
      state    <= IDLE;
    end else begin
      // Keyboard: capture only happens while the flag is clear, so a flag
      // clear and a capture can only coincide when the flag is already 0.
      if (rx_fire) begin
        kbd_buf  <= rxData;
        kbd_flag <= 1'b1;
      end else if (kbd_clear) begin
        kbd_flag <= 1'b0;
      end

      if (k_commit && IR == 3'd5)
        ie <= AC[0];

      // Printer flag: completion of a send wins over a same-cycle clear.
      if (tx_fire || tty_set)
        tty_flag <= 1'b1;
      else if (tty_clear)
        tty_flag <= 1'b0;

      case (state)
        IDLE: begin
          if (tx_start) begin
            tty_buf <= AC;
            state   <= SEND;
          end
        end
        SEND: begin
          if (txReady)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rxReady = ~kbd_flag;
  assign txValid = (state == SEND);
  assign txData  = tty_buf;
  assign irq     = ie & (kbd_flag | tty_flag);
  assign kbdFlag = kbd_flag;
  assign ttyFlag = tty_flag;

endmodule

// File: tb/tb_kl8e_console.sv
// tb_kl8e_console -- scoreboard bench for kl8e_console.
//
// The stimulus process applies one input vector per clock, pushes the
// expected outputs for that cycle (from a behavioural model of the console)
// into a queue, and pushes every byte the printer should emit into a second
// queue. A monitor samples on the falling edge and pops/compares.

module tb_kl8e_console;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] IR;
  logic       IOT603x, IOT604x, DONE;
  logic [7:0] AC;
  logic       acClear;
  logic [7:0] acIn;
  logic       skip, irq;
  logic [7:0] rxData;
  logic       rxValid, rxReady;
  logic [7:0] txData;
  logic       txValid, txReady;
  logic       kbdFlag, ttyFlag;

  always #5 clk = ~clk;

  kl8e_console dut (
    .clk(clk), .reset(reset), .IR(IR), .IOT603x(IOT603x), .IOT604x(IOT604x),
    .DONE(DONE), .AC(AC), .acClear(acClear), .acIn(acIn), .skip(skip),
    .irq(irq), .rxData(rxData), .rxValid(rxValid), .rxReady(rxReady),
    .txData(txData), .txValid(txValid), .txReady(txReady),
    .kbdFlag(kbdFlag), .ttyFlag(ttyFlag)
  );

  typedef struct {
    logic       live;
    logic       ac_clear;
    logic [7:0] ac_in;
    logic       skip;
    logic       irq;
    logic       rx_ready;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       kbd_flag;
    logic       tty_flag;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] tx_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model of the console's visible state.
  logic       known = 1'b0;
  logic [7:0] m_kbd_buf;
  logic       m_kbd_flag;
  logic [7:0] m_tty_buf;
  logic       m_tty_flag;
  logic       m_ie;
  logic       m_sending;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, want, $time);
    end
  endtask

  // One clock of stimulus: drive inputs, predict this cycle's outputs, then
  // advance the model across the rising edge.
  task automatic step(input logic rst, input logic k, input logic t,
                      input logic [2:0] ir, input logic done, input logic [7:0] ac,
                      input logic rxv, input logic [7:0] rxd, input logic txr);
    exp_t e;
    logic rx_hs, tx_hs, kc, tc;
    reset = rst; IOT603x = k; IOT604x = t; IR = ir; DONE = done; AC = ac;
    rxValid = rxv; rxData = rxd; txReady = txr;

    e.live     = known;
    e.ac_clear = k && (ir == 3'd2 || ir == 3'd6);
    e.ac_in    = (k && (ir == 3'd4 || ir == 3'd6)) ? m_kbd_buf : 8'h00;
    e.skip     = 1'b0;
    if (k && ir == 3'd1) e.skip = m_kbd_flag;
    if (t && ir == 3'd1) e.skip = m_tty_flag;
    if (t && ir == 3'd5) e.skip = m_kbd_flag | m_tty_flag;
    e.irq      = m_ie && (m_kbd_flag || m_tty_flag);
    e.rx_ready = !m_kbd_flag;
    e.tx_valid = m_sending;
    e.tx_data  = m_tty_buf;
    e.kbd_flag = m_kbd_flag;
    e.tty_flag = m_tty_flag;
    exp_q.push_back(e);

    @(posedge clk);
    if (rst) begin
      known = 1'b1;
      m_kbd_buf = 8'h00; m_kbd_flag = 1'b0; m_tty_buf = 8'h00;
      m_tty_flag = 1'b0; m_ie = 1'b1; m_sending = 1'b0;
      tx_q.delete();
    end else begin
      kc    = k && done;
      tc    = t && done;
      rx_hs = rxv && !m_kbd_flag;
      tx_hs = m_sending && txr;
      if (kc && (ir == 3'd0 || ir == 3'd2 || ir == 3'd6)) m_kbd_flag = 1'b0;
      if (rx_hs) begin
        m_kbd_flag = 1'b1;
        m_kbd_buf  = rxd;
      end
      if (kc && ir == 3'd5) m_ie = ac[0];
      if (tc && ir == 3'd0) m_tty_flag = 1'b1;
      if (tc && (ir == 3'd2 || ir == 3'd6)) m_tty_flag = 1'b0;
      if (tx_hs) m_tty_flag = 1'b1;
      if (tc && (ir == 3'd4 || ir == 3'd6) && !m_sending) begin
        m_sending = 1'b1;
        m_tty_buf = ac;
        tx_q.push_back(ac);
      end else if (tx_hs) begin
        m_sending = 1'b0;
      end
    end
    #1;
  endtask

  task automatic idle(input logic txr);
    step(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 8'h00, txr);
  endtask

  task automatic kbd(input logic [2:0] ir, input logic done, input logic [7:0] ac);
    step(1'b0, 1'b1, 1'b0, ir, done, ac, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic tty(input logic [2:0] ir, input logic done, input logic [7:0] ac, input logic txr);
    step(1'b0, 1'b0, 1'b1, ir, done, ac, 1'b0, 8'h00, txr);
  endtask

  task automatic rx(input logic [7:0] d);
    step(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 1'b1, d, 1'b0);
  endtask

  // Monitor: per-cycle output comparison plus printer byte-stream scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.live) begin
          check("acClear",  {7'd0, acClear},  {7'd0, e.ac_clear});
          check("acIn",     acIn,             e.ac_in);
          check("skip",     {7'd0, skip},     {7'd0, e.skip});
          check("irq",      {7'd0, irq},      {7'd0, e.irq});
          check("rxReady",  {7'd0, rxReady},  {7'd0, e.rx_ready});
          check("txValid",  {7'd0, txValid},  {7'd0, e.tx_valid});
          if (e.tx_valid) check("txData_held", txData, e.tx_data);
          check("kbdFlag",  {7'd0, kbdFlag},  {7'd0, e.kbd_flag});
          check("ttyFlag",  {7'd0, ttyFlag},  {7'd0, e.tty_flag});
        end
      end
      if (txValid === 1'b1 && txReady === 1'b1) begin
        if (tx_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL tx_extra: got byte %h, expected no transfer (t=%0t)", txData, $time);
        end else begin
          check("tx_byte", txData, tx_q.pop_front());
        end
      end
    end
  end

  initial begin
    reset = 1'b1; IR = 3'd0; IOT603x = 1'b0; IOT604x = 1'b0; DONE = 1'b0;
    AC = 8'h00; rxData = 8'h00; rxValid = 1'b0; txReady = 1'b0;
    @(posedge clk);
    #1;

    // Reset and reset values.
    step(1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    idle(1'b0);

    // Keyboard receive, KSF, KRB.
    rx(8'h41);
    idle(1'b0);
    kbd(3'd1, 1'b0, 8'h00);
    kbd(3'd6, 1'b0, 8'h00);
    kbd(3'd6, 1'b1, 8'h00);
    idle(1'b0);

    // TLS with a stalled receiver, then completion and TSF.
    tty(3'd6, 1'b1, 8'h5A, 1'b0);
    idle(1'b0); idle(1'b0); idle(1'b0);
    idle(1'b1);
    idle(1'b0);
    tty(3'd1, 1'b0, 8'h00, 1'b0);

    // TPC during an active send is ignored.
    tty(3'd4, 1'b1, 8'h30, 1'b0);
    tty(3'd4, 1'b1, 8'h31, 1'b0);
    idle(1'b1);
    idle(1'b1); idle(1'b1); idle(1'b1);

    // Interrupt enable and TSK with only the keyboard flag.
    tty(3'd2, 1'b1, 8'h00, 1'b0);
    kbd(3'd5, 1'b1, 8'h00);
    rx(8'h22);
    idle(1'b0);
    kbd(3'd5, 1'b1, 8'h01);
    idle(1'b0);
    tty(3'd5, 1'b0, 8'h00, 1'b0);
    kbd(3'd2, 1'b1, 8'h00);

    // TCF in the same cycle as send completion: the set wins.
    tty(3'd4, 1'b1, 8'h77, 1'b0);
    tty(3'd2, 1'b1, 8'h00, 1'b1);
    idle(1'b0);

    // Reset during SEND.
    tty(3'd4, 1'b1, 8'h12, 1'b0);
    idle(1'b0);
    step(1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    idle(1'b1);
    kbd(3'd4, 1'b0, 8'h00);
    rx(8'h55);
    idle(1'b0);

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      int sel;
      sel = $urandom_range(0, 2);
      step(($urandom_range(0, 199) == 0),
           (sel == 1), (sel == 2),
           3'($urandom_range(0, 7)),
           ($urandom_range(0, 1) == 1),
           8'($urandom_range(0, 255)),
           ($urandom_range(0, 3) == 0),
           8'($urandom_range(0, 255)),
           ($urandom_range(0, 2) != 0));
    end

    // Drain any byte still in flight, then confirm nothing was lost.
    for (int i = 0; i < 4; i++) idle(1'b1);
    @(negedge clk);
    check("tx_q_drained", 8'(tx_q.size()), 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/kl8e_console.md
# kl8e_console

Console teletype controller, KL8E style, that consumes the group-603x/604x strobes produced by the IOT decoder. It holds the keyboard buffer and flag, the printer buffer and flag, and the interrupt enable. It drives the skip, AC-clear and AC-input terms back into the CPU datapath. Its byte-wide valid/ready ports connect to the UART receiver and transmitter.

## Interface
- No parameters.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high; one clock, sampled on rising edge.
- IR  in  3  IR[2:0], the low octal digit of the instruction (IR[0] = LSB).
- IOT603x  in  1  keyboard device select from IOT decoder (already gated with ~ckFetch).
- IOT604x  in  1  printer device select from IOT decoder.
- DONE  in  1  one-cycle end-of-IOT strobe; all register side effects commit on this cycle.
- AC  in  8  AC[7:0] (AC[0] = PDP AC11), printer data and KIE source.
- acClear  out  1  combinational: clear AC this IOT.
- acIn  out  8  combinational: value ORed into AC; 0 when not reading.
- skip  out  1  combinational: skip next instruction.
- irq  out  1  registered-source interrupt request.
- rxData  in  8 / rxValid  in  1 / rxReady  out  1  keyboard byte stream from UART.
- txData  out  8 / txValid  out  1 / txReady  in  1  printer byte stream to UART.
- kbdFlag, ttyFlag  out  1 each  flag state, for front-panel/debug.

## Operation
- Registers: kbdBuf[7:0], kbdFlag, ttyBuf[7:0], ttyFlag, ie, tx state (IDLE, SEND).
- K = IOT603x & DONE, T = IOT604x & DONE, each marking the commit cycle.
- Keyboard (603x), IR value:
  - 0 KCF: clear kbdFlag.
  - 1 KSF: skip = kbdFlag.
  - 2 KCC: acClear, clear kbdFlag.
  - 4 KRS: acIn = kbdBuf.
  - 5 KIE: ie <= AC[0].
  - 6 KRB: acClear, acIn = kbdBuf, clear kbdFlag.
  - 3, 7: no operation.
- Printer (604x), IR value:
  - 0 TFL: set ttyFlag.
  - 1 TSF: skip = ttyFlag.
  - 2 TCF: clear ttyFlag.
  - 4 TPC: load ttyBuf, start send.
  - 5 TSK: skip = kbdFlag | ttyFlag.
  - 6 TLS: clear ttyFlag, load ttyBuf, start send.
  - 3, 7: no operation.
- Combinational outputs follow IOT603x/IOT604x and IR for the whole IOT, independent of DONE. With no select active, skip = acClear = 0 and acIn = 0.
- Receive: rxReady = ~kbdFlag. When rxValid & rxReady, the cycle captures kbdBuf <= rxData and sets kbdFlag.
- Transmit FSM:
  - IDLE -> SEND on a committing TPC/TLS; ttyBuf <= AC.
  - SEND holds txValid = 1 and txData = ttyBuf until txReady is high.
  - SEND -> IDLE on the txValid & txReady cycle, which also sets ttyFlag.
- irq = ie & (kbdFlag | ttyFlag).

## Timing
- Reset values:
  - kbdBuf = 0, kbdFlag = 0, ttyBuf = 0, ttyFlag = 0, ie = 1, state = IDLE.
  - txValid = 0, rxReady = 1, irq = 0.
  - acClear/skip/acIn are combinational, so they are 0 unless a select is high.
- Reset mid-transfer: txValid drops the next cycle, and no ttyFlag set occurs.
- Register updates from K/T are visible on the cycle after DONE.
- txValid rises on the cycle after the TPC/TLS DONE. ttyFlag rises on the cycle after the handshake.
- rx capture: kbdFlag and kbdBuf update on the cycle after the handshake, and rxReady falls the same cycle.
- Simultaneous events:
  - KCF/KCC/KRB commit while kbdFlag = 1: the flag clears. rxReady rises the next cycle. No capture happens in the commit cycle, because rxReady was 0.
  - TCF or TLS clear in the same cycle as handshake completion: the set wins, and ttyFlag ends at 1.
  - TPC/TLS while in SEND: ttyBuf is not reloaded and no new send starts. The TLS flag clear still applies.
  - K and T are mutually exclusive by decode. No behaviour is required for both high.
- txData is stable for the entire SEND state, including stall cycles with txReady = 0.

## Test plan
- Reset, then rxData=0x41 with rxValid: kbdFlag=1 next cycle, rxReady=0. KSF gives skip=1. KRB gives acClear=1 and acIn=0x41, then kbdFlag=0 and rxReady=1 after DONE.
- TLS with AC=0x5A while txReady=0 for 3 cycles: txValid=1 and txData=0x5A stay held. txReady=1 completes the send. ttyFlag=1 the next cycle, and TSF skips.
- TPC with AC=0x31 issued during SEND of 0x30: the stream carries only 0x30, and no second txValid occurs.
- KIE with AC[0]=0 then kbdFlag set: irq=0. KIE with AC[0]=1: irq=1. TSK skips with only kbdFlag set.
- TCF committed in the same cycle as txReady completion: ttyFlag=1 afterwards.
- Assert reset during SEND: txValid=0 next cycle, ttyFlag=0, ie=1, kbdBuf=0.
